// File: rtl/draw_card_grid.sv
// Card-grid pixel generator: maps the VGA beam position onto a COLS x ROWS card grid in two vertical bands
// and produces card art, frames and a blinking selection frame. Optional macro: DRAW_CARD_BLINK_EN.
module draw_card_grid #(
  parameter int          COLS         = 18,
  parameter int          ROWS         = 8,
  parameter int          TOP_ROWS     = 6,
  parameter int          X0           = 32,
  parameter int          Y0           = 19,
  parameter int          Y1           = 360,
  parameter int          CELL_W       = 32,
  parameter int          CELL_H       = 55,
  parameter int          CARD_H       = 46,
  parameter int          FRAME        = 2,
  parameter logic [11:0] SEL_COLOR    = 12'hFD3,
  parameter logic [11:0] FRAME_COLOR  = 12'hFFF,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pix_en,
  input  logic [9:0]               h_cnt,
  input  logic [9:0]               v_cnt,
  input  logic [ROWS*COLS*6-1:0]   map,
  input  logic [ROWS*COLS-1:0]     sel_card,
  output logic [5:0]               rom_type,
  output logic [5:0]               rom_x,
  output logic [5:0]               rom_y,
  input  logic [11:0]              rom_pixel,
  output logic [11:0]              card_pixel,
  output logic                     card_valid
);

  localparam int NCELL  = ROWS * COLS;
  localparam int X_END  = X0 + COLS * CELL_W;
  localparam int Y0_END = Y0 + TOP_ROWS * CELL_H;
  localparam int Y1_END = Y1 + (ROWS - TOP_ROWS) * CELL_H;

  int         h_w, v_w, col, px, row, py, idx;
  logic       col_in, row_in, in_grid;
  logic [5:0] type_s;
  logic       sel_s, hit_s, frame_s;

  logic [5:0] type_p1_d, x_p1_d, y_p1_d;
  logic       hit_p1_d, frame_p1_d, sel_p1_d;
  logic [5:0] type_p1_q, x_p1_q, y_p1_q;
  logic       hit_p1_q, frame_p1_q, sel_p1_q;

  logic [11:0] pix_p2_d, pix_p2_q;
  logic        vld_p2_d, vld_p2_q;

  logic        blink_on;

  always_comb begin
    h_w    = int'(h_cnt);
    v_w    = int'(v_cnt);
    col_in = (h_w >= X0) && (h_w < X_END);
    col    = (h_w - X0) / CELL_W;
    px     = h_w - X0 - col * CELL_W;

    row_in = 1'b0;
    row    = 0;
    py     = 0;
    if ((v_w >= Y0) && (v_w < Y0_END)) begin
      row_in = 1'b1;
      row    = (v_w - Y0) / CELL_H;
      py     = v_w - Y0 - row * CELL_H;
    end else if ((v_w >= Y1) && (v_w < Y1_END)) begin
      row_in = 1'b1;
      row    = TOP_ROWS + (v_w - Y1) / CELL_H;
      py     = v_w - Y1 - (row - TOP_ROWS) * CELL_H;
    end

    in_grid = col_in && row_in;
    idx     = row * COLS + col;

    // Constant-index mux keeps the map/select lookup free of out-of-range part-selects.
    type_s = 6'd0;
    sel_s  = 1'b0;
    for (int i = 0; i < NCELL; i++) begin
      if (in_grid && (idx == i)) begin
        type_s = map[6*i +: 6];
        sel_s  = sel_card[i];
      end
    end

    hit_s   = in_grid && (py < CARD_H) && (type_s != 6'd0);
    frame_s = (px < FRAME) || (px >= CELL_W - FRAME) ||
              (py < FRAME) || (py >= CARD_H - FRAME);

    type_p1_d  = hit_s ? type_s  : 6'd0;
    x_p1_d     = hit_s ? 6'(px)  : 6'd0;
    y_p1_d     = hit_s ? 6'(py)  : 6'd0;
    hit_p1_d   = hit_s;
    frame_p1_d = hit_s && frame_s;
    sel_p1_d   = hit_s && sel_s;
  end

  // Stage 1 -> stage 2 boundary: rom_pixel now answers the registered address.
  always_comb begin
    pix_p2_d = 12'h000;
    vld_p2_d = 1'b0;
    if (hit_p1_q) begin
      vld_p2_d = 1'b1;
      if (frame_p1_q && sel_p1_q && blink_on) begin
        pix_p2_d = SEL_COLOR;
      end else if (frame_p1_q) begin
        pix_p2_d = FRAME_COLOR;
      end else begin
        pix_p2_d = rom_pixel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      type_p1_q  <= 6'd0;
      x_p1_q     <= 6'd0;
      y_p1_q     <= 6'd0;
      hit_p1_q   <= 1'b0;
      frame_p1_q <= 1'b0;
      sel_p1_q   <= 1'b0;
      pix_p2_q   <= 12'h000;
      vld_p2_q   <= 1'b0;
    end else if (pix_en) begin
      type_p1_q  <= type_p1_d;
      x_p1_q     <= x_p1_d;
      y_p1_q     <= y_p1_d;
      hit_p1_q   <= hit_p1_d;
      frame_p1_q <= frame_p1_d;
      sel_p1_q   <= sel_p1_d;
      pix_p2_q   <= pix_p2_d;
      vld_p2_q   <= vld_p2_d;
    end
  end

`ifdef DRAW_CARD_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0] frame_cnt_d, frame_cnt_q;
  logic            blink_d, blink_q;

  // Frame start is the strobe at the top-left beam position.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (pix_en && (h_cnt == 10'd0) && (v_cnt == 10'd0)) begin
      if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign blink_on = blink_q;
`else
  logic unused_blink_frames;
  assign unused_blink_frames = ^BLINK_FRAMES;
  assign blink_on = 1'b1;
`endif

  assign rom_type   = type_p1_q;
  assign rom_x      = x_p1_q;
  assign rom_y      = y_p1_q;
  assign card_pixel = pix_p2_q;
  assign card_valid = vld_p2_q;

endmodule

// File: tb/tb_draw_card_grid.sv
// Directed bench for draw_card_grid: expected outputs are queued at each pixel strobe and checked one strobe later.
module tb_draw_card_grid;

  localparam int ROWS = 8;
  localparam int COLS = 18;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   pix_en = 1'b0;
  logic [9:0]             h_cnt = 10'd0;
  logic [9:0]             v_cnt = 10'd0;
  logic [ROWS*COLS*6-1:0] map = '0;
  logic [ROWS*COLS-1:0]   sel_card = '0;
  logic [5:0]             rom_type, rom_x, rom_y;
  logic [11:0]            rom_pixel;
  logic [11:0]            card_pixel;
  logic                   card_valid;

  typedef struct {
    logic [11:0] pix;
    logic        vld;
    logic [5:0]  rt;
    logic [5:0]  rx;
    logic [5:0]  ry;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [11:0] last_pix = 12'h000;
  logic        last_vld = 1'b0;

`ifdef DRAW_CARD_BLINK_EN
  localparam logic [11:0] SEL_OFF = 12'hFFF;
`else
  localparam logic [11:0] SEL_OFF = 12'hFD3;
`endif

  draw_card_grid dut (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .map        (map),
    .sel_card   (sel_card),
    .rom_type   (rom_type),
    .rom_x      (rom_x),
    .rom_y      (rom_y),
    .rom_pixel  (rom_pixel),
    .card_pixel (card_pixel),
    .card_valid (card_valid)
  );

  always #5 clk = ~clk;

  // Card-art ROM: one special entry, otherwise the packed address nibbles.
  function automatic logic [11:0] rom_f(input logic [5:0] t, input logic [5:0] x, input logic [5:0] y);
    if (t == 6'd5 && x == 6'd8 && y == 6'd21) return 12'h123;
    return {t[3:0], x[3:0], y[3:0]};
  endfunction

  assign rom_pixel = rom_f(rom_type, rom_x, rom_y);

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_type(input int i, input logic [5:0] t);
    map[6*i +: 6] = t;
  endtask

  // One pixel strobe: checks stage-1 address now, stage-2 output of the previous strobe.
  task automatic step(input int h, input int v, input logic [5:0] et, input logic [5:0] ex,
                      input logic [5:0] ey, input logic [11:0] ep, input logic ev, input string tag);
    exp_t e;
    @(negedge clk);
    h_cnt  = 10'(h);
    v_cnt  = 10'(v);
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".rom_type"}, {6'd0, rom_type}, {6'd0, et});
    chk({tag, ".rom_x"},    {6'd0, rom_x},    {6'd0, ex});
    chk({tag, ".rom_y"},    {6'd0, rom_y},    {6'd0, ey});
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".pixel"}, card_pixel, e.pix);
      chk({e.tag, ".valid"}, {11'd0, card_valid}, {11'd0, e.vld});
      last_pix = e.pix;
      last_vld = e.vld;
    end
    sb.push_back('{ep, ev, et, ex, ey, tag});
  endtask

  task automatic miss(input int h, input int v, input string tag);
    step(h, v, 6'd0, 6'd0, 6'd0, 12'h000, 1'b0, tag);
  endtask

  task automatic hold(input int n);
    @(negedge clk);
    pix_en = 1'b0;
    h_cnt  = 10'd40;
    v_cnt  = 10'd40;
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("hold.pixel", card_pixel, last_pix);
      chk("hold.valid", {11'd0, card_valid}, {11'd0, last_vld});
      chk("hold.rom_type", {6'd0, rom_type}, {6'd0, sb[0].rt});
      chk("hold.rom_x", {6'd0, rom_x}, {6'd0, sb[0].rx});
    end
  endtask

  // Reset asserted together with a strobe: reset must win and flush the pipeline.
  task automatic pulse_reset();
    @(negedge clk);
    rst    = 1'b1;
    pix_en = 1'b1;
    h_cnt  = 10'd40;
    v_cnt  = 10'd40;
    @(posedge clk);
    #1;
    chk("rst.pixel", card_pixel, 12'h000);
    chk("rst.valid", {11'd0, card_valid}, 12'h000);
    chk("rst.rom_type", {6'd0, rom_type}, 12'h000);
    chk("rst.rom_x", {6'd0, rom_x}, 12'h000);
    chk("rst.rom_y", {6'd0, rom_y}, 12'h000);
    sb.delete();
    @(negedge clk);
    rst    = 1'b0;
    pix_en = 1'b0;
    sb.push_back('{12'h000, 1'b0, 6'd0, 6'd0, 6'd0, "post_rst"});
  endtask

  initial begin
    set_type(0, 6'd5);
    set_type(125, 6'd9);
    set_type(126, 6'd3);
    repeat (3) @(posedge clk);
    pulse_reset();

    step(40, 40,   6'd5, 6'd8,  6'd21, 12'h123, 1'b1, "art_idx0");
    step(576, 360, 6'd9, 6'd0,  6'd0,  12'hFFF, 1'b1, "frame_idx125");
    miss(40, 69,  "miss_gap");
    miss(608, 40, "miss_right");
    miss(40, 349, "miss_between");
    miss(64, 40,  "miss_type0");
    step(63, 40,   6'd5, 6'd31, 6'd21, 12'hFFF, 1'b1, "frame_right");
    step(61, 40,   6'd5, 6'd29, 6'd21, 12'h5D5, 1'b1, "art_px29");
    step(40, 64,   6'd5, 6'd8,  6'd45, 12'hFFF, 1'b1, "frame_bottom");
    miss(40, 65,  "miss_py46");
    step(40, 436,  6'd3, 6'd8,  6'd21, 12'h385, 1'b1, "art_row7");
    step(32, 415,  6'd3, 6'd0,  6'd0,  12'hFFF, 1'b1, "frame_row7");
    hold(5);
    miss(40, 470, "miss_below");

    sel_card[0] = 1'b1;
    step(32, 19, 6'd5, 6'd0, 6'd0, 12'hFD3, 1'b1, "sel_on");
    sel_card[0] = 1'b0;
    set_type(0, 6'd0);
    miss(32, 19, "sampled_change");
    set_type(0, 6'd5);
    sel_card[0] = 1'b1;

    repeat (30) miss(0, 0, "fstart_a");
    step(32, 19, 6'd5, 6'd0, 6'd0, SEL_OFF, 1'b1, "sel_after30");
    repeat (30) miss(0, 0, "fstart_b");
    step(32, 19, 6'd5, 6'd0, 6'd0, 12'hFD3, 1'b1, "sel_after60");
    repeat (30) miss(0, 0, "fstart_c");
    step(32, 19, 6'd5, 6'd0, 6'd0, SEL_OFF, 1'b1, "sel_after90");

    step(40, 40,   6'd5, 6'd8, 6'd21, 12'h123, 1'b1, "inflight_a");
    step(576, 360, 6'd9, 6'd0, 6'd0,  12'hFFF, 1'b1, "inflight_b");
    pulse_reset();
    step(32, 19, 6'd5, 6'd0, 6'd0, 12'hFD3, 1'b1, "sel_after_rst");
    miss(700, 0, "flush_a");
    miss(700, 0, "flush_b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
